// File: rtl/writeback_commit_arbiter_if.sv
// Writeback group bundle: unit result inputs and acks on one side, the
// registered commit packet and id retirement notification on the other.
interface writeback_commit_arbiter_if #(
   parameter int NUM_UNITS   = 4,
   parameter int PHYS_ADDR_W = 6,
   parameter int DATA_W      = 32,
   parameter int ID_W        = 3
);
   logic [NUM_UNITS-1:0]                  unit_valid;
   logic [NUM_UNITS-1:0][PHYS_ADDR_W-1:0] unit_phys_addr;
   logic [NUM_UNITS-1:0][DATA_W-1:0]      unit_data;
   logic [NUM_UNITS-1:0][ID_W-1:0]        unit_id;
   logic [NUM_UNITS-1:0]                  unit_ack;
   logic                                  writeback_supress;
   logic                                  commit_valid;
   logic [PHYS_ADDR_W-1:0]                commit_phys_addr;
   logic [DATA_W-1:0]                     commit_data;
   logic                                  id_done_valid;
   logic [ID_W-1:0]                       id_done;

   modport master (
      input  unit_valid, unit_phys_addr, unit_data, unit_id, writeback_supress,
      output unit_ack, commit_valid, commit_phys_addr, commit_data,
             id_done_valid, id_done
   );

   modport slave (
      output unit_valid, unit_phys_addr, unit_data, unit_id, writeback_supress,
      input  unit_ack, commit_valid, commit_phys_addr, commit_data,
             id_done_valid, id_done
   );
endinterface

// File: rtl/writeback_commit_arbiter.sv
// Round-robin selection of one execution-unit result per cycle into a
// registered commit packet plus an instruction-id retirement strobe.
module writeback_commit_arbiter #(
   parameter int NUM_UNITS   = 4,
   parameter int PHYS_ADDR_W = 6,
   parameter int DATA_W      = 32,
   parameter int ID_W        = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   writeback_commit_arbiter_if.master    wb
);
   localparam int PTR_W = $clog2(NUM_UNITS);

   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]       winner_s;
   logic                   grant_s;
   int                     idx_s;
   logic [NUM_UNITS-1:0]   ack_s;

   logic                   commit_valid_q, commit_valid_d;
   logic [PHYS_ADDR_W-1:0] commit_phys_addr_q, commit_phys_addr_d;
   logic [DATA_W-1:0]      commit_data_q, commit_data_d;
   logic                   id_done_valid_q, id_done_valid_d;
   logic [ID_W-1:0]        id_done_q, id_done_d;

   // First valid unit at or after rr_ptr, modulo NUM_UNITS
   always_comb begin
      grant_s  = 1'b0;
      winner_s = {PTR_W{1'b0}};
      idx_s    = 32'sd0;
      for (int k = 32'sd0; k < NUM_UNITS; k++) begin
         idx_s = 32'(rr_ptr_q) + k;
         if (idx_s >= NUM_UNITS) begin
            idx_s = idx_s - NUM_UNITS;
         end else begin
            idx_s = idx_s;
         end
         if (!grant_s && wb.unit_valid[idx_s[PTR_W-1:0]]) begin
            grant_s  = 1'b1;
            winner_s = idx_s[PTR_W-1:0];
         end else begin
            grant_s  = grant_s;
         end
      end
   end

   // Combinational one-hot ack, forced low while reset is held
   always_comb begin
      ack_s = {NUM_UNITS{1'b0}};
      if (grant_s && !rst) begin
         ack_s = {{(NUM_UNITS-1){1'b0}}, 1'b1} << winner_s;
      end else begin
         ack_s = {NUM_UNITS{1'b0}};
      end
   end

   // Next pointer and packet; data fields only move on a grant
   always_comb begin
      rr_ptr_d           = rr_ptr_q;
      commit_valid_d     = 1'b0;
      id_done_valid_d    = 1'b0;
      commit_phys_addr_d = commit_phys_addr_q;
      commit_data_d      = commit_data_q;
      id_done_d          = id_done_q;
      if (grant_s) begin
         rr_ptr_d           = (winner_s == PTR_W'(NUM_UNITS - 1)) ? {PTR_W{1'b0}}
                                                                  : winner_s + {{(PTR_W-1){1'b0}}, 1'b1};
         // x0 destinations and flush-window results still retire their id
         commit_valid_d     = (wb.unit_phys_addr[winner_s] != {PHYS_ADDR_W{1'b0}})
                              && !wb.writeback_supress;
         id_done_valid_d    = 1'b1;
         commit_phys_addr_d = wb.unit_phys_addr[winner_s];
         commit_data_d      = wb.unit_data[winner_s];
         id_done_d          = wb.unit_id[winner_s];
      end else begin
         rr_ptr_d           = rr_ptr_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q           <= {PTR_W{1'b0}};
         commit_valid_q     <= 1'b0;
         commit_phys_addr_q <= {PHYS_ADDR_W{1'b0}};
         commit_data_q      <= {DATA_W{1'b0}};
         id_done_valid_q    <= 1'b0;
         id_done_q          <= {ID_W{1'b0}};
      end else begin
         rr_ptr_q           <= rr_ptr_d;
         commit_valid_q     <= commit_valid_d;
         commit_phys_addr_q <= commit_phys_addr_d;
         commit_data_q      <= commit_data_d;
         id_done_valid_q    <= id_done_valid_d;
         id_done_q          <= id_done_d;
      end
   end

   assign wb.unit_ack         = ack_s;
   assign wb.commit_valid     = commit_valid_q;
   assign wb.commit_phys_addr = commit_phys_addr_q;
   assign wb.commit_data      = commit_data_q;
   assign wb.id_done_valid    = id_done_valid_q;
   assign wb.id_done          = id_done_q;

endmodule

// File: doc/writeback_commit_arbiter.md
Name: writeback_commit_arbiter

Overview:
- Producer side of the commit packet interface consumed by the register file and inuse-tracking logic.
- Collects results from NUM_UNITS execution units in one writeback group, selects one per cycle by round-robin, and drives a registered commit packet (valid, phys_addr, data) plus an instruction-id done notification.
- One instance per writeback group.

Parameters:
- NUM_UNITS, 4, number of execution units sharing this writeback group (2..8).
- PHYS_ADDR_W, 6, physical register address width (64 phys regs).
- DATA_W, 32, result data width.
- ID_W, 3, instruction id width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- unit_valid  input  NUM_UNITS  unit i holds a completed result.
- unit_phys_addr  input  NUM_UNITS x PHYS_ADDR_W  destination phys reg per unit.
- unit_data  input  NUM_UNITS x DATA_W  result per unit.
- unit_id  input  NUM_UNITS x ID_W  instruction id per unit.
- unit_ack  output  NUM_UNITS  one-hot grant; result accepted this cycle.
- writeback_supress  input  1  squash commit_valid generation (flush window).
- commit_valid  output  1  commit packet valid.
- commit_phys_addr  output  PHYS_ADDR_W  commit destination.
- commit_data  output  DATA_W  commit data.
- id_done_valid  output  1  an instruction finished writeback.
- id_done  output  ID_W  id of finished instruction.

Behaviour:
- Reset (async, rst=1): commit_valid=0, id_done_valid=0, commit_phys_addr=0, commit_data=0, id_done=0, rr_ptr=0; unit_ack=0 while rst high.
- Handshake:
  - unit_ack is combinational and is asserted in the same cycle the unit is granted.
  - A unit holds valid, addr, data and id stable until it sees ack.
  - A unit may present a new result the cycle after ack.
  - unit_ack[i] is only ever asserted when unit_valid[i]=1.
  - unit_ack is one-hot or zero.
- Arbitration:
  - Winner = first i with unit_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_UNITS.
  - On a grant, rr_ptr <= (winner+1) mod NUM_UNITS, wrapping from NUM_UNITS-1 to 0.
  - With no valid units, rr_ptr is unchanged.
- Output latency: one cycle. The grant in cycle N appears on the commit_* and id_done* outputs in cycle N+1.
- Output registers:
  - Data fields are loaded only on a grant. They hold their last value otherwise.
  - commit_valid <= grant & (winner_addr != 0) & ~writeback_supress.
  - id_done_valid <= grant. It is asserted even for addr 0 or a suppressed commit, so the id is still retired.
- Phys addr 0 (x0 destination): the unit is acked and id_done is reported, but commit_valid stays 0. commit_valid must never be 1 with commit_phys_addr=0.
- writeback_supress: sampled in the grant cycle. Arbitration and ack proceed normally.
- No backpressure from downstream: the consumer accepts every packet.
- Fairness: a continuously valid unit is granted within NUM_UNITS cycles.
- Mid-operation reset: an in-flight registered packet is discarded, and its valids are cleared immediately (asynchronous). A unit holding valid during reset is granted after reset deasserts, starting the search from unit 0.

Test Plan:
- Single request: unit 2 valid, addr 5, data 0xDEADBEEF, id 3 → unit_ack=0b0100 same cycle; next cycle commit_valid=1, addr 5, data 0xDEADBEEF, id_done_valid=1, id_done=3.
- Round-robin wrap: all 4 units continuously valid from rr_ptr=0 → grants 0,1,2,3,0,1 on consecutive cycles; each ack one-hot; commit_valid=1 every cycle after the first.
- x0 destination: unit 1 valid, addr 0, id 6 → ack asserted; next cycle commit_valid=0, id_done_valid=1, id_done=6.
- Suppression: unit 0 valid, addr 9, writeback_supress=1 in the grant cycle → ack asserted; next cycle commit_valid=0, id_done_valid=1; with supress=0 the following grant commits normally.
- Idle and hold: no units valid for 3 cycles after a grant to unit 3 → commit_valid=0, id_done_valid=0, data regs unchanged, rr_ptr stays 0; units 0 and 3 then valid → unit 0 granted first, then unit 3.
- Async reset mid-stream: assert rst between clock edges while commit_valid=1 → commit_valid and id_done_valid drop to 0 without a clock edge; after release with unit 3 valid and rr_ptr back at 0, unit 3 is granted on the first clock.
